mul_arbiter: RTL and testbench

- Shares one `multiplier` instance between NUM_REQ requesters (e.g. square and multiply paths of the modexp engine).
- Round-robin grant, one operation in flight at a time, result returned to the granted requester only.
- Watchdog aborts a hung multiply.
- Sits between requester blocks and the multiplier's a_in/b_in/valid_in/c_out/valid_out/busy_out ports.

---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/mul_arbiter_rr_picker.sv | 36 +++
 rtl/mul_arbiter.sv | 154 +++++++++++++++
 tb/tb_mul_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and width helpers for the multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_e;

  // Width helpers clamp to 1 so degenerate parameter values still give legal vectors.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int tmr_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Round-robin picker: rotates the request vector by rr_ptr and takes the lowest set bit.
module rr_picker
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [ID_W-1:0]    ptr_in,
  output logic               any_valid_out,
  output logic [ID_W-1:0]    grant_out
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        sum;

  always_comb begin
    dbl           = {req_in, req_in} >> ptr_in;
    rot           = dbl[NUM_REQ-1:0];
    any_valid_out = |rot;
    grant_out     = '0;
    sum           = '0;
    // Descending scan so the smallest offset from ptr_in has the final word.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_in} + (ID_W + 1)'(k);
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
          sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        grant_out = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier between NUM_REQ requesters: round-robin grant, one op in flight,
// result routed back to the granted requester, watchdog abort on a hung multiply.
//
// state   | meaning
// IDLE    | waiting for a request while the multiplier is not busy
// ISSUE   | pulse mul_valid_out with the latched operands
// WAIT    | waiting for mul_valid_in, watchdog running
// RESPOND | strobe resp_valid_out for the granted requester
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic [2*WIDTH-1:0]       resp_c_out,
  output logic                     err_timeout_out,
  output logic                     busy_out,
  output logic [WIDTH-1:0]         mul_a_out,
  output logic [WIDTH-1:0]         mul_b_out,
  output logic                     mul_valid_out,
  input  logic [2*WIDTH-1:0]       mul_c_in,
  input  logic                     mul_valid_in,
  input  logic                     mul_busy_in
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int TMR_W = tmr_width(TIMEOUT);
  localparam logic [TMR_W-1:0] WDOG_LIMIT = TMR_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [TMR_W-1:0]    wdog_q, wdog_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2*WIDTH-1:0]  c_q, c_d;
  logic                err_q, err_d;

  logic                pick_any;
  logic [ID_W-1:0]     pick_id;
  logic [WIDTH-1:0]    a_sel, b_sel;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_in        (req_valid_in),
    .ptr_in        (rr_ptr_q),
    .any_valid_out (pick_any),
    .grant_out     (pick_id)
  );

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == ID_W'(i)) begin
        a_sel = req_a_in[i*WIDTH +: WIDTH];
        b_sel = req_b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    wdog_d         = wdog_q;
    a_d            = a_q;
    b_d            = b_q;
    c_d            = c_q;
    err_d          = 1'b0;
    req_ready_out  = '0;
    resp_valid_out = '0;
    mul_valid_out  = 1'b0;
    case (state_q)
      IDLE: begin
        // Never accept while reset is asserted, so nothing is handshaken away.
        if (pick_any && !mul_busy_in && !rst_in) begin
          req_ready_out = NUM_REQ'(1) << pick_id;
          a_d           = a_sel;
          b_d           = b_sel;
          grant_id_d    = pick_id;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        mul_valid_out = 1'b1;
        wdog_d        = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        if (mul_valid_in) begin
          c_d     = mul_c_in;
          state_d = RESPOND;
        end else if (wdog_q == WDOG_LIMIT) begin
          err_d    = 1'b1;
          rr_ptr_d = next_id(grant_id_q);
          state_d  = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESPOND: begin
        resp_valid_out = NUM_REQ'(1) << grant_id_q;
        rr_ptr_d       = next_id(grant_id_q);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      wdog_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      wdog_q     <= wdog_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      err_q      <= err_d;
    end
  end

  assign busy_out        = (state_q != IDLE);
  assign mul_a_out       = a_q;
  assign mul_b_out       = b_q;
  assign resp_c_out      = c_q;
  assign err_timeout_out = err_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a fixed-latency behavioural multiplier.
module tb_mul_arbiter;

  localparam int W  = 256;
  localparam int NR = 2;
  localparam int TO = 64;
  localparam int L  = 10;

  logic            clk;
  logic            rst_in;
  logic [NR-1:0]   req_valid_in;
  logic [NR*W-1:0] req_a_in, req_b_in;
  logic [NR-1:0]   req_ready_out, resp_valid_out;
  logic [2*W-1:0]  resp_c_out;
  logic            err_timeout_out, busy_out;
  logic [W-1:0]    mul_a_out, mul_b_out;
  logic            mul_valid_out;
  logic [2*W-1:0]  mul_c_in;
  logic            mul_valid_in, mul_busy_in;

  mul_arbiter #(.WIDTH(W), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_a_in        (req_a_in),
    .req_b_in        (req_b_in),
    .req_ready_out   (req_ready_out),
    .resp_valid_out  (resp_valid_out),
    .resp_c_out      (resp_c_out),
    .err_timeout_out (err_timeout_out),
    .busy_out        (busy_out),
    .mul_a_out       (mul_a_out),
    .mul_b_out       (mul_b_out),
    .mul_valid_out   (mul_valid_out),
    .mul_c_in        (mul_c_in),
    .mul_valid_in    (mul_valid_in),
    .mul_busy_in     (mul_busy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: result valid L cycles after valid_in, busy while in flight.
  logic [L-1:0]   pipe_v = '0;
  logic [2*W-1:0] pipe_d [L];
  logic           stub_dead = 1'b0;
  logic           busy_force = 1'b0;
  logic           inj_valid = 1'b0;
  logic [2*W-1:0] inj_c = '0;

  always @(posedge clk) begin
    pipe_v[0] <= mul_valid_out;
    pipe_d[0] <= (2*W)'(mul_a_out) * (2*W)'(mul_b_out);
    for (int s = 1; s < L; s++) begin
      pipe_v[s] <= pipe_v[s-1];
      pipe_d[s] <= pipe_d[s-1];
    end
  end

  assign mul_valid_in = (pipe_v[L-1] & ~stub_dead) | inj_valid;
  assign mul_c_in     = inj_valid ? inj_c : pipe_d[L-1];
  assign mul_busy_in  = busy_force | (|pipe_v);

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int             id;
    logic [2*W-1:0] c;
  } exp_t;
  exp_t sb[$];

  int acc_log[$];
  int acc_cnt = 0, resp_cnt = 0, issue_cnt = 0, err_cnt = 0;
  int last_acc = 0, issue_cyc = 0, err_cyc = 0;
  logic chk_lat = 1'b1;

  always @(negedge clk) begin
    if (req_ready_out != '0) begin
      acc_log.push_back(req_ready_out[1] ? 1 : 0);
      last_acc = cyc;
      acc_cnt++;
    end
    if (mul_valid_out) begin
      issue_cyc = cyc;
      issue_cnt++;
    end
    if (err_timeout_out) begin
      err_cyc = cyc;
      err_cnt++;
    end
    if (resp_valid_out != '0) begin
      if (sb.size() == 0) begin
        check("resp_while_sb_empty", (2*W)'(resp_valid_out), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_onehot", (2*W)'(resp_valid_out), (2*W)'(1) << e.id);
        check("resp_c", resp_c_out, e.c);
        if (chk_lat) check("resp_latency", (2*W)'(cyc - last_acc), (2*W)'(L + 2));
      end
      resp_cnt++;
    end
  end

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a_in[id*W +: W] = a;
    req_b_in[id*W +: W] = b;
  endtask

  task automatic push_exp(input int id, input logic [2*W-1:0] c);
    exp_t e;
    e.id = id;
    e.c  = c;
    sb.push_back(e);
  endtask

  task automatic wait_acc(input int n);
    int g = 0;
    while (acc_cnt < n && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (acc_cnt < n) check("accept_timeout", (2*W)'(acc_cnt), (2*W)'(n));
  endtask

  task automatic wait_resp(input int n);
    int g = 0;
    while (resp_cnt < n && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (resp_cnt < n) check("resp_timeout", (2*W)'(resp_cnt), (2*W)'(n));
  endtask

  task automatic wait_issue(input int n);
    int g = 0;
    while (issue_cnt < n && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (issue_cnt < n) check("issue_timeout", (2*W)'(issue_cnt), (2*W)'(n));
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 500) begin
      @(posedge clk); #1; g++;
    end
  endtask

  // Request from a mask of requesters until n accepts, then drop and wait for the results.
  task automatic run_ops(input logic [NR-1:0] mask, input int n);
    int ab, rb;
    ab = acc_cnt;
    rb = resp_cnt;
    req_valid_in = mask;
    wait_acc(ab + n);
    req_valid_in = '0;
    wait_resp(rb + n);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
  endtask

  typedef struct {
    int             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ab, eb, rb, bad;
    tbl[0] = '{0, 256'd13, 256'd23, 512'd299};
    tbl[1] = '{1, 256'd65535, 256'd65535, 512'd4294836225};
    tbl[2] = '{0, 256'd0, 256'hdead_beef_0123_4567_89ab_cdef, 512'd0};
    tbl[3] = '{1, '1, '1, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}};
    tbl[4] = '{1, 256'd1, 256'h1234_5678_9abc_def0, 512'h1234_5678_9abc_def0};
    tbl[5] = '{0, 256'd1 << 255, 256'd2, 512'd1 << 256};

    rst_in = 1'b1;
    req_valid_in = '0;
    req_a_in = '0;
    req_b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", (2*W)'(req_ready_out), '0);
    check("rst_resp_valid", (2*W)'(resp_valid_out), '0);
    check("rst_resp_c", resp_c_out, '0);
    check("rst_busy", (2*W)'(busy_out), '0);
    check("rst_err", (2*W)'(err_timeout_out), '0);
    check("rst_mul_valid", (2*W)'(mul_valid_out), '0);
    check("rst_mul_ab", (2*W)'({mul_a_out, mul_b_out}), '0);
    rst_in = 1'b0;

    for (int v = 0; v < 6; v++) begin
      set_ops(tbl[v].id, tbl[v].a, tbl[v].b);
      push_exp(tbl[v].id, tbl[v].exp);
      run_ops(NR'(1) << tbl[v].id, 1);
    end

    // Both valid straight after reset: requester 0 first, then 1.
    do_reset();
    set_ops(0, 256'd308113484502254276214653084379069091219,
               256'd193690634914747133184576417654126124729);
    set_ops(1, 256'd7, 256'd9);
    push_exp(0, 512'd59678696439036731833174790408137592454209857625042749229656692202628272654651);
    push_exp(1, 512'd63);
    ab = acc_log.size();
    run_ops(2'b11, 2);
    check("simul_order0", (2*W)'(acc_log[ab]), (2*W)'(0));
    check("simul_order1", (2*W)'(acc_log[ab+1]), (2*W)'(1));

    // Continuous contention: strict rotation including the 1 -> 0 wrap.
    set_ops(0, 256'd3, 256'd5);
    set_ops(1, 256'd11, 256'd13);
    for (int k = 0; k < 4; k++) push_exp(k % 2, (k % 2 == 0) ? 512'd15 : 512'd143);
    ab = acc_log.size();
    run_ops(2'b11, 4);
    for (int k = 0; k < 4; k++) check("fair_order", (2*W)'(acc_log[ab+k]), (2*W)'(k % 2));

    // Busy stall: nothing accepted or issued while the multiplier reports busy.
    set_ops(0, 256'd1000, 256'd1000);
    push_exp(0, 512'd1000000);
    ab = acc_cnt;
    rb = resp_cnt;
    bad = 0;
    busy_force = 1'b1;
    req_valid_in = 2'b01;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready_out != '0 || mul_valid_out) bad++;
    end
    check("busy_stall_quiet", (2*W)'(bad), '0);
    check("busy_stall_no_acc", (2*W)'(acc_cnt), (2*W)'(ab));
    @(posedge clk); #1;
    busy_force = 1'b0;
    wait_acc(ab + 1);
    req_valid_in = '0;
    wait_resp(rb + 1);

    // Watchdog: dead multiplier, abort 64 cycles after WAIT is entered.
    stub_dead = 1'b1;
    set_ops(0, 256'd21, 256'd2);
    eb = err_cnt;
    rb = resp_cnt;
    ab = issue_cnt;
    req_valid_in = 2'b01;
    wait_acc(acc_cnt + 1);
    req_valid_in = '0;
    wait_issue(ab + 1);
    begin
      int g = 0;
      while (err_cnt == eb && g < 200) begin
        @(posedge clk); #1; g++;
      end
    end
    check("wdog_fired", (2*W)'(err_cnt), (2*W)'(eb + 1));
    check("wdog_delay", (2*W)'(err_cyc - (issue_cyc + 1)), (2*W)'(TO));
    check("wdog_pulse_width", (2*W)'(err_timeout_out), '0);
    check("wdog_idle", (2*W)'(busy_out), '0);
    check("wdog_no_resp", (2*W)'(resp_cnt), (2*W)'(rb));
    stub_dead = 1'b0;
    set_ops(0, 256'd2, 256'd2);
    set_ops(1, 256'd7, 256'd9);
    push_exp(1, 512'd63);
    run_ops(2'b11, 1);
    check("wdog_next_grant", (2*W)'(acc_log[acc_log.size()-1]), (2*W)'(1));

    // Result in the same cycle as the watchdog limit: result wins.
    stub_dead = 1'b1;
    chk_lat = 1'b0;
    set_ops(0, 256'd5, 256'd5);
    push_exp(0, 512'd12345);
    eb = err_cnt;
    rb = resp_cnt;
    ab = issue_cnt;
    req_valid_in = 2'b01;
    wait_acc(acc_cnt + 1);
    req_valid_in = '0;
    wait_issue(ab + 1);
    wait_cyc(issue_cyc + TO);
    inj_c = 512'd12345;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    wait_resp(rb + 1);
    check("tie_no_err", (2*W)'(err_cnt), (2*W)'(eb));
    chk_lat = 1'b1;

    // Valid from the multiplier while IDLE is ignored.
    rb = resp_cnt;
    inj_c = 512'd999;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_valid_ignored", (2*W)'(resp_cnt), (2*W)'(rb));
    check("idle_valid_not_busy", (2*W)'(busy_out), '0);

    // Reset 50 cycles into WAIT, then a stale result, then a fresh op.
    set_ops(0, 256'd13, 256'd23);
    rb = resp_cnt;
    ab = issue_cnt;
    req_valid_in = 2'b01;
    wait_acc(acc_cnt + 1);
    req_valid_in = '0;
    wait_issue(ab + 1);
    wait_cyc(issue_cyc + 1 + 50);
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    check("midrst_busy", (2*W)'(busy_out), '0);
    check("midrst_resp_c", resp_c_out, '0);
    check("midrst_mul_ab", (2*W)'({mul_a_out, mul_b_out}), '0);
    check("midrst_outs", (2*W)'({req_ready_out, resp_valid_out, err_timeout_out, mul_valid_out}), '0);
    inj_c = 512'd299;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stale_ignored", (2*W)'(resp_cnt), (2*W)'(rb));
    stub_dead = 1'b0;
    push_exp(0, 512'd299);
    run_ops(2'b01, 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", (2*W)'(sb.size()), '0);
    check("err_total", (2*W)'(err_cnt), (2*W)'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
